// File: rtl/cnt_bank_pkg.sv
// cnt_bank_pkg: shared types and defaults for the counter bank controller
//   ADDR_W_DEF / DATA_W_DEF : default index and counter widths
//   state_t                 : controller FSM states
//   gnt_t                   : last-grant pointer encoding for the increment arbiter
package cnt_bank_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  typedef enum logic {GNT_0 = 1'b0, GNT_1 = 1'b1} gnt_t;
endpackage

// File: rtl/cnt_bank_mem.sv
// cnt_bank_mem: 2^ADDR_W x DATA_W flop array, two async read ports, one sync write port, no reset
//   clk              : write clock
//   we/waddr/wdata   : synchronous write port
//   raddr_a/rdata_a  : combinational read port (increment source)
//   raddr_b/rdata_b  : combinational read port (read requester)
module cnt_bank_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/cnt_bank_ctrl.sv
// cnt_bank_ctrl: clear-sweep FSM, round-robin increment arbiter and read port for a counter bank
//   clk, rst_n (async, active-low)
//   clr_req / clr_busy                 : start a zeroing sweep / sweep in progress
//   inc{0,1}_valid/addr/ready          : increment requesters (one grant per cycle)
//   rd_valid/addr/ready, rd_data(_valid): read port, 1-cycle registered result
//   CNT_BANK_SAT_EN defined: counters saturate at all-ones; undefined: counters wrap
module cnt_bank_ctrl
  import cnt_bank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              inc0_valid,
  input  logic [ADDR_W-1:0] inc0_addr,
  output logic              inc0_ready,
  input  logic              inc1_valid,
  input  logic [ADDR_W-1:0] inc1_addr,
  output logic              inc1_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data
);
  state_t state, state_nx;
  gnt_t last, last_nx;
  logic [ADDR_W-1:0] sweep, waddr, src_addr;
  logic [DATA_W-1:0] wdata, src, rdat, bumped;
  logic run, g0, g1, we, rd_fire;
  cnt_bank_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(src_addr), .rdata_a(src), .raddr_b(rd_addr), .rdata_b(rdat)
  );
`ifdef CNT_BANK_SAT_EN
  assign bumped = (src == '1) ? src : src + 1'b1;
`else
  assign bumped = src + 1'b1;
`endif
  always_comb begin
    run = state == ST_RUN;
    g0 = run && !clr_req && inc0_valid && (!inc1_valid || last == GNT_1);
    g1 = run && !clr_req && inc1_valid && (!inc0_valid || last == GNT_0);
    rd_fire = run && !clr_req && rd_valid;
    state_nx = run ? (clr_req ? ST_CLEAR : ST_RUN) : (sweep == '1 ? ST_RUN : ST_CLEAR);
    last_nx = g0 ? GNT_0 : g1 ? GNT_1 : last;
    src_addr = g1 ? inc1_addr : inc0_addr;
    we = !run || g0 || g1;
    waddr = run ? src_addr : sweep;
    wdata = run ? bumped : '0;
  end
  assign clr_busy = !run;
  assign inc0_ready = g0;
  assign inc1_ready = g1;
  assign rd_ready = run && !clr_req;
  // sweep wraps to 0 on its last word, so it is already 0 whenever a new sweep starts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_CLEAR;
      last <= GNT_1;
      sweep <= '0;
      rd_data_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_nx;
      last <= last_nx;
      sweep <= run ? '0 : sweep + 1'b1;
      rd_data_valid <= rd_fire;
      if (rd_fire) rd_data <= rdat;
    end
endmodule

// File: doc/cnt_bank_ctrl.md
# cnt_bank_ctrl

Controller that owns a 256 x 8-bit counter bank and shares it between two increment requesters and one read requester. After reset, and on a clear request, it sequences a full zeroing sweep. Increments are arbitrated round-robin onto the bank's single write port. It sits between the pin-facing logic of a tile and the counter storage, replacing ad-hoc direct indexing of the array.

## Interface
- ADDR_W, 8, counter index width; bank depth is 2^ADDR_W
- DATA_W, 8, counter width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr_req  in  1  single-cycle pulse; start a clear sweep
- clr_busy  out  1  high while a sweep runs
- inc0_valid  in  1  requester 0 wants to increment inc0_addr
- inc0_addr  in  ADDR_W  requester 0 index
- inc0_ready  out  1  requester 0 granted this cycle
- inc1_valid, inc1_addr, inc1_ready  same as requester 0, for requester 1
- rd_valid  in  1  read request
- rd_addr  in  ADDR_W  read index
- rd_ready  out  1  read accepted this cycle
- rd_data_valid  out  1  rd_data holds an accepted read's result
- rd_data  out  DATA_W  counter value

## Operation
- A transfer occurs when valid and ready are both high on a rising clk edge.
- The FSM has two states:
  - ST_CLEAR: a sweep pointer runs 0..2^ADDR_W-1, one word zeroed per cycle. clr_busy=1. All readies are 0.
  - ST_RUN: normal service. clr_busy=0.
- Transitions:
  - Reset enters ST_CLEAR with the pointer at 0.
  - ST_CLEAR moves to ST_RUN in the cycle after the last word is written.
  - ST_RUN moves to ST_CLEAR when clr_req=1. Requests in that same cycle are not granted.
  - clr_req during ST_CLEAR is ignored. The sweep does not restart.
- Increment arbitration (ST_RUN only):
  - At most one increment per cycle.
  - Only one requester valid: grant it.
  - Both valid: grant the requester not granted most recently. The last-grant pointer updates on every grant and resets to "1", so inc0 wins the first tie.
  - inc*_ready is combinational from the valids, the state and the pointer.
- Increment effect: mem[addr] <= mem[addr] + 1, modulo 2^DATA_W by default (see Configuration). Both requesters valid on the same address still gives one increment per cycle.
- Read: rd_ready = (state == ST_RUN) && !clr_req, independent of increments.
  - A read in the same cycle as an increment to the same address returns the pre-increment value.
- Bank contents are not reset. Contents before the first sweep completes are never observable.

## Timing
- Reset values: clr_busy=1, inc0_ready=0, inc1_ready=0, rd_ready=0, rd_data_valid=0, rd_data=0.
- Sweep length is exactly 2^ADDR_W cycles (256 by default). The first grant is possible in cycle 256 after rst_n deasserts.
- Read latency is 1 cycle. rd_data and rd_data_valid are registered. rd_data_valid pulses for one cycle per accepted read. rd_data holds its value between reads.
- Increment write latency is 1 cycle. A read accepted in the cycle after a grant sees the new value.
- Back-to-back increments to one address from either requester accumulate with no lost updates.
- rst_n asserted mid-sweep or mid-operation:
  - All outputs return to reset values immediately.
  - The sweep restarts from 0 after release.
  - A pending rd_data_valid is dropped.

## Configuration
- CNT_BANK_SAT_EN:
  - Defined: increments saturate at 2^DATA_W-1. A counter at 255 stays 255.
  - Undefined: increments wrap, 255+1 gives 0.
- Arbitration and timing are identical in both builds.

## Structure
- The shared package cnt_bank_pkg holds:
  - the state enum (ST_CLEAR, ST_RUN)
  - default ADDR_W and DATA_W constants
  - the grant-pointer encoding
- Sub-module cnt_bank_mem: a 2^ADDR_W x DATA_W flop array with:
  - two combinational read ports (increment source and read port)
  - one synchronous write port
  - no reset
- The controller contains the FSM, sweep counter, arbiter, adder/saturator and read-data register.

## Test plan
- Release reset, hold rd_valid=1 at rd_addr=0x00 → clr_busy=1 for 256 cycles, rd_ready first high in cycle 256, rd_data=0x00 with rd_data_valid one cycle later.
- inc0 valid at 0x10 for 3 cycles, then read 0x10 → rd_data=0x03. Then inc1 at 0x10 for 2 cycles, read → 0x05.
- Both requesters valid at 0x20 for 6 cycles → grants alternate inc0, inc1, inc0, ... (3 each). Read 0x20 → 0x06.
- Increment 0x30 300 times, then read → 0x2C without CNT_BANK_SAT_EN, 0xFF with it.
- Load 0x40 to 0x07, pulse clr_req, pulse clr_req again 10 cycles later → clr_busy lasts exactly 256 cycles from the first pulse. Read 0x40 → 0x00.
- Same-cycle increment and read of 0x50 (value 0x02) → rd_data=0x02. Next read → 0x03.
